// File: rtl/debug_host_master_pkg.sv
// Shared debug-port constants and host-master FSM encoding.
package debug_host_master_pkg;

    localparam int unsigned DbgAddrW = 3;
    localparam int unsigned DbgDataW = 8;
    localparam int unsigned CntW     = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/debug_stop_sync.sv
// DBG_STOP tracking: optional 2-flop synchronizer, STOPPED register and rising-edge pulse.
// Define DEBUG_HOST_STOP_SYNC_EN when the core runs in an unrelated clock domain.
module debug_stop_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_dbg_stop,
    output logic o_stopped,
    output logic o_stop_event
);

    logic w_stop_src;
    logic r_stopped;
    logic r_stop_event;

`ifdef DEBUG_HOST_STOP_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_dbg_stop};
        end
    end

    assign w_stop_src = r_sync[1];
`else
    assign w_stop_src = i_dbg_stop;
`endif

    // The event is registered alongside STOPPED so both rise on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stopped    <= 1'b0;
            r_stop_event <= 1'b0;
        end else begin
            r_stopped    <= w_stop_src;
            r_stop_event <= w_stop_src & ~r_stopped;
        end
    end

    assign o_stopped    = r_stopped;
    assign o_stop_event = r_stop_event;

endmodule

// File: rtl/debug_host_master.sv
// Host-side initiator for the 8-bit debug port: turns single-beat requests into timed
// strobe cycles. STOP tracking depth is selected by DEBUG_HOST_STOP_SYNC_EN.
module debug_host_master
    import debug_host_master_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WR,
    input  logic [DbgAddrW-1:0] REQ_ADDR,
    input  logic [DbgDataW-1:0] REQ_WDATA,
    output logic                RSP_VALID,
    output logic [DbgDataW-1:0] RSP_RDATA,
    output logic [DbgAddrW-1:0] DBG_ADDR,
    output logic [DbgDataW-1:0] DBG_DOUT,
    input  logic [DbgDataW-1:0] DBG_DIN,
    output logic                DBG_OE,
    output logic                DBG_WRN,
    output logic                DBG_RDN,
    input  logic                DBG_STOP,
    output logic                STOPPED,
    output logic                STOP_EVENT
);

    localparam logic [CntW-1:0] SetupLoad = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYC - 1);

    dbg_state_e          r_state, w_state_d;
    logic [CntW-1:0]     r_cnt, w_cnt_d;
    logic                r_wr, w_wr_d;
    logic [DbgAddrW-1:0] r_addr, w_addr_d;
    logic [DbgDataW-1:0] r_dout, w_dout_d;
    logic [DbgDataW-1:0] r_rdata, w_rdata_d;
    logic                r_oe, w_oe_d;
    logic                r_wrn, w_wrn_d;
    logic                r_rdn, w_rdn_d;
    logic                r_rsp_valid, w_rsp_valid_d;
    logic                r_ready, w_ready_d;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_rdata     <= '0;
            r_oe        <= 1'b0;
            r_wrn       <= 1'b1;
            r_rdn       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_wr        <= w_wr_d;
            r_addr      <= w_addr_d;
            r_dout      <= w_dout_d;
            r_rdata     <= w_rdata_d;
            r_oe        <= w_oe_d;
            r_wrn       <= w_wrn_d;
            r_rdn       <= w_rdn_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_ready     <= w_ready_d;
        end
    end

    // Strobe outputs are computed for the next cycle so they leave the flops glitch-free.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_wr_d        = r_wr;
        w_addr_d      = r_addr;
        w_dout_d      = r_dout;
        w_rdata_d     = r_rdata;
        w_oe_d        = r_oe;
        w_wrn_d       = 1'b1;
        w_rdn_d       = 1'b1;
        w_rsp_valid_d = 1'b0;

        case (r_state)
            StIdle: begin
                if (REQ_VALID && r_ready) begin
                    w_wr_d    = REQ_WR;
                    w_addr_d  = REQ_ADDR;
                    w_dout_d  = REQ_WDATA;
                    w_oe_d    = REQ_WR;
                    w_cnt_d   = SetupLoad;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (r_cnt == '0) begin
                    w_cnt_d   = PulseLoad;
                    w_state_d = StStrobe;
                    w_wrn_d   = ~r_wr;
                    w_rdn_d   = r_wr;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StStrobe: begin
                if (r_cnt == '0) begin
                    w_rdata_d = r_wr ? '0 : DBG_DIN;
                    w_cnt_d   = HoldLoad;
                    w_state_d = StHold;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                    w_wrn_d = ~r_wr;
                    w_rdn_d = r_wr;
                end
            end
            StHold: begin
                if (r_cnt == '0) begin
                    w_state_d     = StIdle;
                    w_oe_d        = 1'b0;
                    w_rsp_valid_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_ready_d = (w_state_d == StIdle);
    end

    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rdata;
    assign DBG_ADDR  = r_addr;
    assign DBG_DOUT  = r_dout;
    assign DBG_OE    = r_oe;
    assign DBG_WRN   = r_wrn;
    assign DBG_RDN   = r_rdn;

    debug_stop_sync u_stop_sync (
        .i_clk        (CLK),
        .i_rst_n      (RESETN),
        .i_dbg_stop   (DBG_STOP),
        .o_stopped    (STOPPED),
        .o_stop_event (STOP_EVENT)
    );

endmodule
